// File: rtl/chargen_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | chargen_pkg: shared types and constants for the chargen family   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package chargen_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t CHAR_CR = 8'h0D;
  localparam byte_t CHAR_LF = 8'h0A;

  // Active-low strobe levels
  localparam logic nT = 1'b0;
  localparam logic nF = 1'b1;

  typedef enum logic [1:0] {
    S_CHAR = 2'd0,
    S_CR   = 2'd1,
    S_LF   = 2'd2
  } chargen_state_t;

endpackage
`default_nettype wire

// File: rtl/chargen_line_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | chargen_line_if: byte-write handshake between generator and FIFO |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface chargen_line_if;
  import chargen_pkg::*;

  logic  n_cs;
  byte_t port;
  logic  n_wr;
  logic  n_eol;

  modport master (input n_cs, output port, output n_wr, output n_eol);
  modport slave  (output n_cs, input port, input n_wr, input n_eol);

endinterface
`default_nettype wire

// File: rtl/chargen_wrap_inc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | chargen_wrap_inc: modular increment over [FIRSTCHAR, LASTCHAR]   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module chargen_wrap_inc
  import chargen_pkg::*;
#(
  parameter byte_t FIRSTCHAR = 8'h21,
  parameter byte_t LASTCHAR  = 8'h7E
) (
  input  byte_t val_i,
  output byte_t next_o
);

  // Compare before incrementing so LASTCHAR=0xFF never depends on overflow
  assign next_o = (val_i == LASTCHAR) ? FIRSTCHAR : val_i + 8'd1;

endmodule
`default_nettype wire

// File: rtl/chargen_line.sv
`default_nettype none
// +------------------------------------------------------------------+
// | chargen_line: RFC 864 rotating-pattern line generator            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module chargen_line
  import chargen_pkg::*;
#(
  parameter byte_t       FIRSTCHAR = 8'h21,
  parameter byte_t       LASTCHAR  = 8'h7E,
  parameter int unsigned LINELEN   = 72,
  parameter bit          EOL_CRLF  = 1'b1
) (
  input wire logic       clk,
  input wire logic       n_rst,
  chargen_line_if.master bus
);

  localparam int COL_W = $clog2(LINELEN + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINELEN - 1);

  chargen_state_t   state_q;
  byte_t            cur_q;
  byte_t            lstart_q;
  logic [COL_W-1:0] col_q;
  byte_t            port_q;
  logic             n_wr_q;
  logic             n_eol_q;

  byte_t cur_next;
  byte_t lstart_next;

  chargen_wrap_inc #(.FIRSTCHAR(FIRSTCHAR), .LASTCHAR(LASTCHAR)) u_inc_cur (
    .val_i  (cur_q),
    .next_o (cur_next)
  );

  chargen_wrap_inc #(.FIRSTCHAR(FIRSTCHAR), .LASTCHAR(LASTCHAR)) u_inc_lstart (
    .val_i  (lstart_q),
    .next_o (lstart_next)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_CHAR;
      cur_q    <= FIRSTCHAR;
      lstart_q <= FIRSTCHAR;
      col_q    <= '0;
      port_q   <= 8'h00;
      n_wr_q   <= nF;
      n_eol_q  <= nF;
    end else begin
      port_q  <= 8'h00;
      n_wr_q  <= nF;
      n_eol_q <= nF;
      if (bus.n_cs == nT) begin
        unique case (state_q)
          S_CHAR: begin
            port_q <= cur_q;
            n_wr_q <= nT;
            cur_q  <= cur_next;
            if (col_q == COL_LAST) begin
              col_q   <= '0;
              state_q <= EOL_CRLF ? S_CR : S_LF;
            end else begin
              col_q <= col_q + COL_W'(1);
            end
          end
          S_CR: begin
            port_q  <= CHAR_CR;
            n_wr_q  <= nT;
            state_q <= S_LF;
          end
          S_LF: begin
            // Next line starts one character later than this one
            port_q   <= CHAR_LF;
            n_wr_q   <= nT;
            n_eol_q  <= nT;
            lstart_q <= lstart_next;
            cur_q    <= lstart_next;
            state_q  <= S_CHAR;
          end
          default: state_q <= S_CHAR;
        endcase
      end
    end
  end

  assign bus.port  = port_q;
  assign bus.n_wr  = n_wr_q;
  assign bus.n_eol = n_eol_q;

endmodule
`default_nettype wire

// File: tb/tb_chargen_line.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_chargen_line: scoreboard bench over three parameter sets      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_chargen_line;
  import chargen_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] n_rst;

  chargen_line_if if0 ();
  chargen_line_if if1 ();
  chargen_line_if if2 ();

  chargen_line dut0 (.clk(clk), .n_rst(n_rst[0]), .bus(if0));
  chargen_line #(.FIRSTCHAR(8'h61), .LASTCHAR(8'h63), .LINELEN(4), .EOL_CRLF(1'b0))
    dut1 (.clk(clk), .n_rst(n_rst[1]), .bus(if1));
  chargen_line #(.FIRSTCHAR(8'hFF), .LASTCHAR(8'hFF), .LINELEN(3), .EOL_CRLF(1'b1))
    dut2 (.clk(clk), .n_rst(n_rst[2]), .bus(if2));

  wire [7:0] op [3];
  wire       ow [3];
  wire       oe [3];
  assign op[0] = if0.port;  assign ow[0] = if0.n_wr;  assign oe[0] = if0.n_eol;
  assign op[1] = if1.port;  assign ow[1] = if1.n_wr;  assign oe[1] = if1.n_eol;
  assign op[2] = if2.port;  assign ow[2] = if2.n_wr;  assign oe[2] = if2.n_eol;

  // Reference model parameters, one entry per DUT
  localparam int MF  [3] = '{33, 97, 255};
  localparam int ML  [3] = '{126, 99, 255};
  localparam int MLEN[3] = '{72, 4, 3};
  localparam int MCR [3] = '{1, 0, 1};

  int mst[3], mcur[3], mls[3], mcol[3], lines[3], eols[3];
  logic [8:0] q0[$], q1[$], q2[$];   // {expected n_eol, expected byte}

  int vectors = 0;
  int errs    = 0;

  // Observed-stream records
  bit       track0 = 1'b1;
  int       lineno = 0, col0 = 0;
  byte_t    first0[96], last0[96];
  int       len0[96];
  byte_t    c1[20], c2[20];
  int       cap1 = 0, cap2 = 0;

  function automatic int adv(input int k, input int v);
    return (v == ML[k]) ? MF[k] : v + 1;
  endfunction

  task automatic mreset(input int k);
    mst[k] = 0; mcur[k] = MF[k]; mls[k] = MF[k]; mcol[k] = 0;
  endtask

  task automatic qpush(input int k, input logic [8:0] e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [8:0] qpop(input int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic mstep(input int k);
    logic [8:0] e;
    case (mst[k])
      0: begin
        e = {1'b1, 8'(mcur[k])};
        mcur[k] = adv(k, mcur[k]);
        if (mcol[k] == MLEN[k] - 1) begin
          mcol[k] = 0;
          mst[k]  = (MCR[k] != 0) ? 1 : 2;
        end else begin
          mcol[k]++;
        end
      end
      1: begin
        e = {1'b1, 8'h0D};
        mst[k] = 2;
      end
      default: begin
        e = {1'b0, 8'h0A};
        mls[k]  = adv(k, mls[k]);
        mcur[k] = mls[k];
        mst[k]  = 0;
        lines[k]++;
      end
    endcase
    qpush(k, e);
  endtask

  task automatic record(input int k, input byte_t b);
    if (k == 0 && track0) begin
      if (b == 8'h0A) begin
        if (lineno < 96) len0[lineno] = col0;
        lineno++;
        col0 = 0;
      end else if (b != 8'h0D) begin
        if (lineno < 96) begin
          if (col0 == 0) first0[lineno] = b;
          last0[lineno] = b;
        end
        col0++;
      end
    end else if (k == 1 && cap1 < 20) begin
      c1[cap1] = b; cap1++;
    end else if (k == 2 && cap2 < 20) begin
      c2[cap2] = b; cap2++;
    end
  endtask

  task automatic chk(input int k);
    logic [8:0] e, got;
    int n;
    got = {oe[k], op[k]};
    n   = qsize(k);
    vectors++;
    if (ow[k] === nT) begin
      if (oe[k] === nT) eols[k]++;
      if (n == 0) begin
        errs++;
        $error("FAIL sb%0d_write: got port=%h n_eol=%b, expected no write", k, op[k], oe[k]);
      end else begin
        e = qpop(k);
        assert (got === e) else begin
          errs++;
          $error("FAIL sb%0d_byte: got n_eol=%b port=%h, expected n_eol=%b port=%h",
                 k, got[8], got[7:0], e[8], e[7:0]);
        end
      end
      record(k, op[k]);
    end else begin
      assert (ow[k] === nF && op[k] === 8'h00 && oe[k] === nF && n == 0) else begin
        errs++;
        $error("FAIL sb%0d_idle: got n_wr=%b port=%h n_eol=%b pending=%0d, expected n_wr=1 port=00 n_eol=1 pending=0",
               k, ow[k], op[k], oe[k], n);
      end
    end
  endtask

  task automatic expect_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive n_cs, advance models for enabled DUTs, check after the edge
  task automatic cycle(input logic c0, input logic c1_, input logic c2_);
    if0.n_cs = c0; if1.n_cs = c1_; if2.n_cs = c2_;
    if (c0 == nT && n_rst[0])  mstep(0);
    if (c1_ == nT && n_rst[1]) mstep(1);
    if (c2_ == nT && n_rst[2]) mstep(2);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk(k);
  endtask

  initial begin
    string s1;
    n_rst = 3'b000;
    if0.n_cs = nF; if1.n_cs = nF; if2.n_cs = nF;
    for (int k = 0; k < 3; k++) begin
      mreset(k); lines[k] = 0; eols[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk(k);
    @(negedge clk);
    n_rst = 3'b111;

    // Stall after 0x30, then resume
    repeat (16) cycle(nT, nT, nT);
    expect_eq("pre_stall_byte", {8'h0, op[0]}, 16'h0030);
    repeat (5) cycle(nF, nT, nT);
    cycle(nT, nT, nT);
    expect_eq("post_stall_byte", {8'h0, op[0]}, 16'h0031);

    // Stall between CR and LF
    for (int i = 0; i < 200 && mst[0] != 2; i++) cycle(nT, nT, nT);
    expect_eq("cr_before_stall", {7'h0, ow[0], op[0]}, 16'h000D);
    repeat (5) cycle(nF, nT, nT);
    cycle(nT, nT, nT);
    expect_eq("lf_after_stall", {7'h0, oe[0], op[0]}, 16'h000A);

    // Run through a whole pattern period
    for (int i = 0; i < 8000 && lineno < 96; i++) cycle(nT, nT, nT);
    expect_eq("period_reached", 16'(lineno >= 96), 16'd1);
    expect_eq("line0_first", {8'h0, first0[0]},  16'h0021);
    expect_eq("line0_last",  {8'h0, last0[0]},   16'h0068);
    expect_eq("line0_len",   16'(len0[0]),       16'd72);
    expect_eq("line1_first", {8'h0, first0[1]},  16'h0022);
    expect_eq("line1_last",  {8'h0, last0[1]},   16'h0069);
    // N=94 lines per period: line 93 is the last to start at LASTCHAR
    expect_eq("line93_first", {8'h0, first0[93]}, 16'h007E);
    expect_eq("line93_last",  {8'h0, last0[93]},  16'h0067);
    expect_eq("line94_first", {8'h0, first0[94]}, 16'h0021);

    s1 = "abca\nbcab\ncabc\nabca\n";
    expect_eq("dut1_captured", 16'(cap1), 16'd20);
    for (int i = 0; i < 20; i++) expect_eq("dut1_stream", {8'h0, c1[i]}, {8'h0, s1[i]});
    expect_eq("dut2_captured", 16'(cap2), 16'd20);
    for (int i = 0; i < 20; i++)
      expect_eq("dut2_stream", {8'h0, c2[i]},
                (i % 5 == 3) ? 16'h000D : (i % 5 == 4) ? 16'h000A : 16'h00FF);

    // Asynchronous reset while DUT0 sits in S_CR
    track0 = 1'b0;
    for (int i = 0; i < 200 && mst[0] != 1; i++) cycle(nT, nT, nT);
    expect_eq("reach_s_cr", 16'(mst[0]), 16'd1);
    #2;
    n_rst[0] = 1'b0;
    #1;
    expect_eq("async_rst_outputs", {6'h0, ow[0], oe[0], op[0]}, 16'h0300);
    mreset(0);
    @(negedge clk);
    n_rst[0] = 1'b1;
    cycle(nT, nT, nT);
    expect_eq("first_after_rst", {7'h0, ow[0], op[0]}, 16'h0021);

    // Random enable
    for (int i = 0; i < 10000; i++)
      cycle(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 1)));
    for (int k = 0; k < 3; k++) expect_eq("eol_vs_lines", 16'(eols[k]), 16'(lines[k]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
`default_nettype wire
